// File: rtl/store_commit_ctrl.sv
// store_commit_ctrl: orders store/AMO/fence commits against store buffer drain status
package config_pkg;
  typedef struct packed {
    logic RVA;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{RVA: 1'b0};
endpackage

module store_commit_ctrl #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        commit_st_valid_i,
  input  logic        commit_amo_valid_i,
  input  logic        fence_i,
  input  logic        commit_ready_i,
  input  logic        no_st_pending_i,
  input  logic        store_buffer_empty_i,
  input  logic        amo_ack_i,
  output logic        commit_o,
  output logic        amo_valid_commit_o,
  output logic        stall_st_pending_o,
  output logic        commit_ack_o,
  output logic        fence_done_o,
  output logic        timeout_o,
  output logic [15:0] stall_cnt_o,
  input  logic        clear_stats_i
);
  typedef enum logic [1:0] {IDLE, AMO_DRAIN, AMO_WAIT, FENCE_DRAIN} state_e;
  state_e      r_state, w_state_next;
  logic [31:0] r_wd;
  logic [15:0] r_stall_cnt;
  logic        r_timeout;
  logic        w_amo_req, w_wd_hit;
  assign w_amo_req = commit_amo_valid_i & CVA6Cfg.RVA;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  // strobes are gated by rst_ni so nothing leaks out while reset is held
  always_comb begin
    w_state_next       = r_state;
    commit_o           = 1'b0;
    amo_valid_commit_o = 1'b0;
    fence_done_o       = 1'b0;
    commit_ack_o       = 1'b0;
    case (r_state)
      IDLE:
        if (w_amo_req) w_state_next = AMO_DRAIN;
        else if (fence_i) w_state_next = FENCE_DRAIN;
        else if (commit_st_valid_i && commit_ready_i && rst_ni) begin
          commit_o     = 1'b1;
          commit_ack_o = 1'b1;
        end
      AMO_DRAIN:
        if (flush_i) w_state_next = IDLE;
        else if (no_st_pending_i) begin
          amo_valid_commit_o = CVA6Cfg.RVA;
          w_state_next       = AMO_WAIT;
        end
      AMO_WAIT:
        if (amo_ack_i) begin
          commit_ack_o = 1'b1;
          w_state_next = IDLE;
        end
      FENCE_DRAIN:
        if (flush_i) w_state_next = IDLE;
        else if (store_buffer_empty_i) begin
          fence_done_o = 1'b1;
          commit_ack_o = 1'b1;
          w_state_next = IDLE;
        end
      default: w_state_next = IDLE;
    endcase
  end
  assign w_wd_hit = (DrainTimeout != 0) && (r_state != IDLE) && (w_state_next == r_state)
                    && (r_wd + 32'd1 == DrainTimeout);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wd        <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wd        <= (w_state_next != r_state || r_state == IDLE) ? '0 : r_wd + 32'd1;
      r_timeout   <= flush_i ? 1'b0 : (r_timeout | w_wd_hit);
      r_stall_cnt <= clear_stats_i ? '0 :
                     (commit_st_valid_i && !commit_o && r_stall_cnt != '1) ? r_stall_cnt + 16'd1 :
                     r_stall_cnt;
    end
  assign stall_st_pending_o = (r_state != IDLE);
  assign timeout_o          = r_timeout;
  assign stall_cnt_o        = r_stall_cnt;
endmodule

// File: doc/store_commit_ctrl.md
# store_commit_ctrl

Commit-side sequencer for the store unit. Turns commit-stage requests (plain store, AMO, fence) into the store unit's `commit_i` / `amo_valid_commit_i` strobes, and orders them against the store buffer's drain status. AMOs issue only after all committed stores have left. Fences complete only once the buffer is empty. Sits between the commit stage and the store unit and drives `stall_st_pending_i` while a drain is in progress.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration. When `RVA`=0, the AMO path is tied off: `amo_valid_commit_o`=0 and AMO requests are never acked.
- `DrainTimeout`, default 1024: cycle budget for any drain/wait state. 0 disables the watchdog.

Ports (name, direction, width, meaning):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush.
- `commit_st_valid_i` in 1: commit stage requests commit of a plain store.
- `commit_amo_valid_i` in 1: commit stage requests commit of an AMO.
- `fence_i` in 1: commit stage requests a store drain (fence).
- `commit_ready_i` in 1: store buffer can accept a commit.
- `no_st_pending_i` in 1: no committed store outstanding.
- `store_buffer_empty_i` in 1: speculative and commit queues both empty.
- `amo_ack_i` in 1: AMO response from the AMO buffer (`amo_resp.ack`).
- `commit_o` out 1: connects to store unit `commit_i`.
- `amo_valid_commit_o` out 1: connects to store unit `amo_valid_commit_i`.
- `stall_st_pending_o` out 1: connects to store unit `stall_st_pending_i`.
- `commit_ack_o` out 1: request retired, pulse to the commit stage.
- `fence_done_o` out 1: fence complete, pulse.
- `timeout_o` out 1: sticky watchdog flag.
- `stall_cnt_o` out 16: saturating count of cycles in which a store commit was blocked.
- `clear_stats_i` in 1: synchronous clear of `stall_cnt_o`.

## Operation
FSM states: IDLE, AMO_DRAIN, AMO_WAIT, FENCE_DRAIN. Reset state is IDLE.

IDLE:
- Request priority: AMO > fence > store. Lower-priority requests are not acked in that cycle.
- `commit_amo_valid_i`: go to AMO_DRAIN.
- `fence_i`: go to FENCE_DRAIN.
- `commit_st_valid_i` && `commit_ready_i`: assert `commit_o`=1 and `commit_ack_o`=1 combinationally. Stay in IDLE.
- `commit_st_valid_i` && !`commit_ready_i`: no ack; `stall_cnt_o` increments.

AMO_DRAIN:
- `stall_st_pending_o`=1.
- When `no_st_pending_i`=1: assert `amo_valid_commit_o`=1 for that single cycle and go to AMO_WAIT.

AMO_WAIT:
- `stall_st_pending_o`=1.
- On `amo_ack_i`: assert `commit_ack_o`=1 that cycle and go to IDLE.

FENCE_DRAIN:
- `stall_st_pending_o`=1.
- When `store_buffer_empty_i`=1: assert `fence_done_o`=1 and `commit_ack_o`=1 that cycle, then go to IDLE.

Flush:
- In AMO_DRAIN or FENCE_DRAIN, `flush_i` returns the FSM to IDLE with no pulses.
- In AMO_WAIT, `flush_i` is ignored; the AMO is already architecturally committed and must complete.
- In IDLE, `commit_o` is not gated by `flush_i`, because committed stores are architectural.

Watchdog:
- A 32-bit counter clears on every state entry and increments each cycle in AMO_DRAIN, AMO_WAIT and FENCE_DRAIN.
- When the count reaches `DrainTimeout` (and `DrainTimeout` != 0), `timeout_o` sets.
- `timeout_o` clears on `flush_i` or reset. The state is unaffected.

`stall_cnt_o`:
- Increments in any cycle where `commit_st_valid_i`=1 and no store commit is issued. This includes non-IDLE states.
- Saturates at 0xFFFF.
- `clear_stats_i` has priority over increment.

## Timing
- Reset values: all outputs 0, `stall_cnt_o`=0, state IDLE.
- Store commit: 0-cycle latency, combinational from `commit_st_valid_i` and `commit_ready_i`.
- AMO: earliest ack is 2 cycles after the request.
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `amo_valid_commit_o` if `no_st_pending_i` is high.
  - Cycle ≥2: `amo_ack_i` is sampled only in AMO_WAIT; an ack seen in any other state is ignored.
- Fence: earliest `fence_done_o` is 1 cycle after the request.
- `amo_valid_commit_o`, `fence_done_o` and `commit_ack_o` are each at most one cycle wide per request.
- `stall_st_pending_o` is a Moore output: high exactly while state ≠ IDLE.
- Reset mid-operation forces IDLE immediately and drops all strobes. Any AMO in flight is abandoned and handled by the store unit's own reset.

## Test plan
1. Back-to-back stores, `commit_ready_i`=1 for 4 cycles -> 4 `commit_o` and 4 `commit_ack_o` pulses; `stall_cnt_o`=0.
2. Store with `commit_ready_i`=0 for 3 cycles, then 1 -> `stall_cnt_o`=3; single `commit_o` on the 4th cycle.
3. AMO with `no_st_pending_i`=0 for 2 cycles, `amo_ack_i` 3 cycles after issue -> `amo_valid_commit_o` at cycle 3 only; `commit_ack_o` at cycle 6; `stall_st_pending_o` high cycles 1–6.
4. Fence, then `flush_i` while in FENCE_DRAIN -> IDLE next cycle; `fence_done_o` never asserted. Repeat with `flush_i` during AMO_WAIT -> `commit_ack_o` still fires on `amo_ack_i`.
5. `DrainTimeout`=8, fence with `store_buffer_empty_i`=0 held -> `timeout_o`=1 after 8 cycles and stays set until `flush_i`.
6. AMO and store requested in the same IDLE cycle -> no `commit_o`, go to AMO_DRAIN; `stall_cnt_o` increments.
